// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM states, sample offsets around the bit
// centre, and the parity helper also used by the transmitter.
package uart_rx_pkg;

  localparam int DATA_WIDTH = 8;

  // Offsets relative to PRESCALE/2: three sample points, then the vote point.
  localparam int SAMPLE_OFS_LO  = -1;
  localparam int SAMPLE_OFS_MID = 0;
  localparam int SAMPLE_OFS_HI  = 1;
  localparam int VOTE_OFS       = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // typ=0 even parity, typ=1 odd parity.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic typ);
    return typ ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Bit-timing counters for the UART receiver: edge_cnt walks one bit period,
// bit_cnt indexes the data bits; flags the vote point and bit boundary.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE = 8,
  localparam int EW = $clog2(PRESCALE),
  localparam int BW = $clog2(DATA_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cnt_en_i,
  input  logic          cnt_clr_i,
  input  logic          bit_en_i,
  output logic [EW-1:0] edge_cnt_o,
  output logic [BW-1:0] bit_cnt_o,
  output logic          bit_done_o,
  output logic          vote_pt_o
);

  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          last_edge;

  assign last_edge = (edge_cnt_q == EW'(PRESCALE - 1));

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (cnt_clr_i) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (cnt_en_i) begin
      if (last_edge) begin
        edge_cnt_d = '0;
        if (bit_en_i) bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt_o = edge_cnt_q;
  assign bit_cnt_o  = bit_cnt_q;
  assign bit_done_o = cnt_en_i && last_edge;
  assign vote_pt_o  = cnt_en_i && (edge_cnt_q == EW'(PRESCALE / 2 + VOTE_OFS));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises RX_IN, majority-votes three centre samples per
// bit, deserialises 8N1/8P1 frames and pulses valid or an error per frame.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH);

  logic sync1_q, sync2_q, rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s = sync2_q;

  logic          cnt_en, cnt_clr, bit_en, bit_done, vote_pt;
  logic [EW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;

  uart_rx_edge_bit_counter #(
    .PRESCALE(PRESCALE)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .cnt_en_i   (cnt_en),
    .cnt_clr_i  (cnt_clr),
    .bit_en_i   (bit_en),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .bit_done_o (bit_done),
    .vote_pt_o  (vote_pt)
  );

  logic [2:0] samples;
  logic       voted;

  for (genvar gi = 0; gi < 3; gi++) begin : g_samp
    localparam int SAMPLE_PT = PRESCALE / 2 + SAMPLE_OFS_LO + gi;
    logic samp_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           samp_q <= 1'b1;
      else if (edge_cnt == EW'(SAMPLE_PT)) samp_q <= rx_s;
    end
    assign samples[gi] = samp_q;
  end

  assign voted = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                 (samples[1] & samples[2]);

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    p_data_d  = p_data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bad_d = par_bad_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    cnt_en    = 1'b1;
    cnt_clr   = 1'b0;
    bit_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_en  = 1'b0;
        cnt_clr = 1'b1;
        if (!rx_s) begin
          state_d   = START;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (vote_pt && voted) state_d = IDLE;
        else if (bit_done)    state_d = DATA;
      end
      DATA: begin
        bit_en = 1'b1;
        if (vote_pt) data_d[bit_cnt] = voted;
        if (bit_done && bit_cnt == BW'(DATA_WIDTH - 1))
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (vote_pt) par_bad_d = (voted != parity_bit(data_q, par_typ_q));
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        // Leave at the vote point so a back-to-back start edge is not missed.
        if (vote_pt) begin
          state_d = IDLE;
          if (par_bad_q) begin
            pe_d = 1'b1;
          end else if (voted) begin
            dv_d     = 1'b1;
            p_data_d = data_q;
          end else begin
            se_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      p_data_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      p_data_q  <= p_data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bad_q <= par_bad_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stop_err   = se_q;

endmodule
